// File: rtl/pwm_cmd_decoder.sv
// pwm_cmd_decoder
//   Turns a UART byte stream into PWM configuration updates and duty-data
//   FIFO writes.
//   Packets:  [CMD_CFG][NB config bytes, LSB first]
//             [CMD_DATA][LEN][LEN data bytes]
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   rx_data/rx_valid  received byte and its one-cycle strobe
//   fifo_full         PWM FIFO full flag (clk domain)
//   pwm_config_data   committed configuration word
//   config_update     pulse when pwm_config_data is reloaded
//   wr_fifo_enable    FIFO write strobe
//   wr_fifo_data      FIFO write data (holds between writes)
//   busy              a packet is in progress
//   pkt_done          pulse on packet completion
//   err               pulse on bad opcode, dropped data byte or timeout
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for an opcode byte
// CFG    | collecting config payload bytes into shadow
// LEN    | waiting for the data-packet length byte
// DATA   | forwarding data bytes to the PWM FIFO
module pwm_cmd_decoder #(
  parameter int                            PWM_FIFO_WIDTH    = 8,
  parameter int                            CONFIG_DATA_WIDTH = 32,
  parameter logic [CONFIG_DATA_WIDTH-1:0]  CONFIG_RESET      = '0,
  parameter int                            TIMEOUT_CYCLES    = 100000,
  parameter logic [7:0]                    CMD_CFG           = 8'h01,
  parameter logic [7:0]                    CMD_DATA          = 8'h02
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PWM_FIFO_WIDTH-1:0]     rx_data,
  input  logic                          rx_valid,
  input  logic                          fifo_full,
  output logic [CONFIG_DATA_WIDTH-1:0]  pwm_config_data,
  output logic                          config_update,
  output logic                          wr_fifo_enable,
  output logic [PWM_FIFO_WIDTH-1:0]     wr_fifo_data,
  output logic                          busy,
  output logic                          pkt_done,
  output logic                          err
);

  localparam int NB  = CONFIG_DATA_WIDTH / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);
  localparam logic [TW-1:0]  TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CFG,
    S_LEN,
    S_DATA
  } state_t;

  state_t                         state, state_nxt;
  logic [CONFIG_DATA_WIDTH-1:0]   shadow, shadow_nxt;
  logic [BCW-1:0]                 byte_cnt, byte_cnt_nxt;
  logic [7:0]                     rem_cnt, rem_cnt_nxt;
  logic [TW-1:0]                  tmo_cnt, tmo_cnt_nxt;
  logic [CONFIG_DATA_WIDTH-1:0]   cfg_nxt;
  logic                           cfg_upd_nxt;
  logic                           wr_en_nxt;
  logic [PWM_FIFO_WIDTH-1:0]      wr_data_nxt;
  logic                           done_nxt;
  logic                           err_nxt;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      shadow          <= '0;
      byte_cnt        <= '0;
      rem_cnt         <= '0;
      tmo_cnt         <= '0;
      pwm_config_data <= CONFIG_RESET;
      config_update   <= 1'b0;
      wr_fifo_enable  <= 1'b0;
      wr_fifo_data    <= '0;
      pkt_done        <= 1'b0;
      err             <= 1'b0;
    end else begin
      state           <= state_nxt;
      shadow          <= shadow_nxt;
      byte_cnt        <= byte_cnt_nxt;
      rem_cnt         <= rem_cnt_nxt;
      tmo_cnt         <= tmo_cnt_nxt;
      pwm_config_data <= cfg_nxt;
      config_update   <= cfg_upd_nxt;
      wr_fifo_enable  <= wr_en_nxt;
      wr_fifo_data    <= wr_data_nxt;
      pkt_done        <= done_nxt;
      err             <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shadow_nxt   = shadow;
    byte_cnt_nxt = byte_cnt;
    rem_cnt_nxt  = rem_cnt;
    tmo_cnt_nxt  = tmo_cnt;
    cfg_nxt      = pwm_config_data;
    cfg_upd_nxt  = 1'b0;
    wr_en_nxt    = 1'b0;
    wr_data_nxt  = wr_fifo_data;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;

    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data[7:0] == CMD_CFG) begin
            state_nxt    = S_CFG;
            byte_cnt_nxt = '0;
            shadow_nxt   = '0;
          end else if (rx_data[7:0] == CMD_DATA) begin
            state_nxt = S_LEN;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      S_CFG: begin
        if (rx_valid) begin
          shadow_nxt[8*byte_cnt +: 8] = rx_data[7:0];
          if (byte_cnt == LAST_BYTE) begin
            // commit the whole word at once, including the byte arriving now
            cfg_nxt      = shadow_nxt;
            cfg_upd_nxt  = 1'b1;
            done_nxt     = 1'b1;
            state_nxt    = S_IDLE;
            byte_cnt_nxt = '0;
          end else begin
            byte_cnt_nxt = byte_cnt + 1'b1;
          end
        end
      end

      S_LEN: begin
        if (rx_valid) begin
          rem_cnt_nxt = rx_data[7:0];
          if (rx_data[7:0] == 8'd0) begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          // a byte hitting a full FIFO is dropped but still consumes length
          if (!fifo_full) begin
            wr_en_nxt   = 1'b1;
            wr_data_nxt = rx_data;
          end else begin
            err_nxt = 1'b1;
          end
          rem_cnt_nxt = rem_cnt - 1'b1;
          if (rem_cnt == 8'd1) begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase

    // Inter-byte timer: reloaded by every byte, counts down while a packet
    // is open. A byte in the terminal cycle takes priority over expiry.
    if (rx_valid) begin
      tmo_cnt_nxt = TMO_LOAD;
    end else if (state != S_IDLE) begin
      if (tmo_cnt == '0) begin
        state_nxt    = S_IDLE;
        err_nxt      = 1'b1;
        shadow_nxt   = '0;
        byte_cnt_nxt = '0;
        rem_cnt_nxt  = '0;
      end else begin
        tmo_cnt_nxt = tmo_cnt - 1'b1;
      end
    end

    if (state_nxt == S_IDLE) begin
      tmo_cnt_nxt = '0;
    end
  end

endmodule

// File: tb/tb_pwm_cmd_decoder.sv
module tb_pwm_cmd_decoder;

  localparam int          TMO     = 20;
  localparam logic [31:0] CFG_RST = 32'hCAFE_0000;

  localparam int EV_WR   = 1;
  localparam int EV_CFG  = 2;
  localparam int EV_DONE = 4;
  localparam int EV_ERR  = 8;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        fifo_full;
  logic [31:0] pwm_config_data;
  logic        config_update;
  logic        wr_fifo_enable;
  logic [7:0]  wr_fifo_data;
  logic        busy;
  logic        pkt_done;
  logic        err;

  pwm_cmd_decoder #(
    .PWM_FIFO_WIDTH    (8),
    .CONFIG_DATA_WIDTH (32),
    .CONFIG_RESET      (CFG_RST),
    .TIMEOUT_CYCLES    (TMO),
    .CMD_CFG           (8'h01),
    .CMD_DATA          (8'h02)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .fifo_full       (fifo_full),
    .pwm_config_data (pwm_config_data),
    .config_update   (config_update),
    .wr_fifo_enable  (wr_fifo_enable),
    .wr_fifo_data    (wr_fifo_data),
    .busy            (busy),
    .pkt_done        (pkt_done),
    .err             (err)
  );

  typedef struct {
    int          kind;
    int          cyc;
    int          tol;
    logic [31:0] data;
  } ev_t;

  ev_t         ev_q[$];
  ev_t         ev;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          idx;
  logic [3:0]  strb;
  logic [31:0] obsd[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic string kind_name(input int k);
    case (k)
      0:       return "wr";
      1:       return "cfg";
      2:       return "done";
      default: return "err";
    endcase
  endfunction

  task automatic push_ev(input int kind, input int at, input int tol, input logic [31:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.tol  = tol;
    e.data = d;
    ev_q.push_back(e);
  endtask

  // Drive one byte for one cycle; mask lists the strobes it should cause
  // one cycle later (wr/cfg carry d as their expected data).
  task automatic send(input logic [7:0] b, input bit full, input int mask, input logic [31:0] d);
    rx_data   = b;
    rx_valid  = 1'b1;
    fifo_full = full;
    for (int k = 0; k < 4; k++)
      if (mask[k]) push_ev(k, cyc + 1, 0, d);
    @(negedge clk);
    rx_valid  = 1'b0;
    fifo_full = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    strb    = {err, pkt_done, config_update, wr_fifo_enable};
    obsd[0] = {24'd0, wr_fifo_data};
    obsd[1] = pwm_config_data;
    obsd[2] = '0;
    obsd[3] = '0;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) begin
        idx = -1;
        for (int i = 0; i < ev_q.size(); i++)
          if (idx < 0 && ev_q[i].kind == k) idx = i;
        if (idx < 0) begin
          check({kind_name(k), "_unexpected"}, 1, 0);
        end else begin
          ev = ev_q[idx];
          ev_q.delete(idx);
          if (ev.tol == 0)
            check({kind_name(k), "_cycle"}, cyc, ev.cyc);
          else
            check({kind_name(k), "_window"},
                  (cyc >= ev.cyc - ev.tol && cyc <= ev.cyc + ev.tol), 1);
          if (k < 2) check({kind_name(k), "_data"}, obsd[k], ev.data);
        end
      end
    end
    for (int i = ev_q.size() - 1; i >= 0; i--) begin
      if (ev_q[i].cyc + ev_q[i].tol < cyc) begin
        check({kind_name(ev_q[i].kind), "_missing"}, 0, 1);
        ev_q.delete(i);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t_be;
    rst       = 1'b1;
    rx_data   = '0;
    rx_valid  = 1'b0;
    fifo_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cfg", pwm_config_data, CFG_RST);
    check("rst_strobes", {busy, pkt_done, err, config_update, wr_fifo_enable}, 0);
    check("rst_wr_data", wr_fifo_data, 0);
    rst = 1'b0;
    idle(2);

    // config write
    send(8'h01, 0, 0, 0);
    check("cfg_busy", busy, 1);
    send(8'h78, 0, 0, 0);
    send(8'h56, 0, 0, 0);
    send(8'h34, 0, 0, 0);
    check("cfg_unchanged_partial", pwm_config_data, CFG_RST);
    send(8'h12, 0, EV_CFG | EV_DONE, 32'h1234_5678);
    check("cfg_busy_after", busy, 0);
    idle(2);
    check("cfg_value", pwm_config_data, 32'h1234_5678);

    // data packet, back to back
    send(8'h02, 0, 0, 0);
    send(8'h03, 0, 0, 0);
    send(8'hAA, 0, EV_WR, 32'hAA);
    send(8'hBB, 0, EV_WR, 32'hBB);
    send(8'hCC, 0, EV_WR | EV_DONE, 32'hCC);
    idle(3);
    check("wr_data_hold", wr_fifo_data, 8'hCC);

    // last byte dropped on full
    send(8'h02, 0, 0, 0);
    send(8'h02, 0, 0, 0);
    send(8'h11, 0, EV_WR, 32'h11);
    send(8'h22, 1, EV_ERR | EV_DONE, 0);
    check("drop_busy", busy, 0);
    idle(2);
    check("drop_wr_data_hold", wr_fifo_data, 8'h11);

    // timeout inside a config packet
    send(8'h01, 0, 0, 0);
    send(8'hEF, 0, 0, 0);
    send(8'hBE, 0, 0, 0);
    t_be = cyc;
    push_ev(3, t_be + TMO, 1, 0);
    idle(TMO + 5);
    check("tmo_busy", busy, 0);
    check("tmo_cfg_kept", pwm_config_data, 32'h1234_5678);
    send(8'h01, 0, 0, 0);
    send(8'h04, 0, 0, 0);
    send(8'h03, 0, 0, 0);
    send(8'h02, 0, 0, 0);
    send(8'h01, 0, EV_CFG | EV_DONE, 32'h0102_0304);
    idle(2);
    check("tmo_next_cfg", pwm_config_data, 32'h0102_0304);

    // bad opcode, empty data packet
    send(8'h7F, 0, EV_ERR, 0);
    check("bad_op_busy", busy, 0);
    idle(1);
    send(8'h02, 0, 0, 0);
    send(8'h00, 0, EV_DONE, 0);
    check("len0_busy", busy, 0);
    idle(2);

    // gap just under the timeout is not an error
    send(8'h02, 0, 0, 0);
    idle(TMO - 3);
    check("gap_busy", busy, 1);
    send(8'h01, 0, 0, 0);
    idle(TMO - 3);
    send(8'h5A, 0, EV_WR | EV_DONE, 32'h5A);
    idle(2);

    // reset in the middle of a config packet
    send(8'h01, 0, 0, 0);
    send(8'hAA, 0, 0, 0);
    send(8'hBB, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("midrst_cfg", pwm_config_data, CFG_RST);
    check("midrst_outs", {busy, pkt_done, err, config_update, wr_fifo_enable}, 0);
    check("midrst_wr_data", wr_fifo_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    send(8'h01, 0, 0, 0);
    send(8'hDD, 0, 0, 0);
    send(8'hCC, 0, 0, 0);
    send(8'hBB, 0, 0, 0);
    send(8'hAA, 0, EV_CFG | EV_DONE, 32'hAABB_CCDD);
    idle(3);
    check("post_rst_cfg", pwm_config_data, 32'hAABB_CCDD);

    idle(3);
    check("events_left", ev_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_cmd_decoder.md
Name: pwm_cmd_decoder

Overview:
- Byte-stream command decoder directly upstream of the PWM physical stage, clocked in the PWM write-side domain (clk2 at the PWM_phy boundary).
- Accepts framed bytes from a UART receiver and produces the configuration word (pwm_config_data) and the duty-data FIFO write stream (wr_fifo_enable / wr_fifo_data).
- Handles packet framing, atomic config commit, FIFO-full drop and inter-byte timeout abort.

Parameters:
- PWM_FIFO_WIDTH, 8: width of the rx byte and of the FIFO write data.
- CONFIG_DATA_WIDTH, 32: config word width. Must be a multiple of 8. NB = CONFIG_DATA_WIDTH/8 payload bytes.
- CONFIG_RESET, 0: reset value of pwm_config_data.
- TIMEOUT_CYCLES, 100000: idle clk cycles allowed between bytes inside a packet.
- CMD_CFG, 8'h01: opcode for a config write.
- CMD_DATA, 8'h02: opcode for a data write.

Ports:
- clk  input  1  clock
- rst  input  1  reset (see interface rules)
- rx_data  input  PWM_FIFO_WIDTH  received byte
- rx_valid  input  1  one-cycle strobe per byte; no back-pressure exists
- fifo_full  input  1  PWM FIFO full flag, synchronous to clk
- pwm_config_data  output  CONFIG_DATA_WIDTH  registered config word
- config_update  output  1  one-cycle pulse when pwm_config_data changes
- wr_fifo_enable  output  1  FIFO write strobe
- wr_fifo_data  output  PWM_FIFO_WIDTH  FIFO write data
- busy  output  1  high whenever state != IDLE
- pkt_done  output  1  one-cycle pulse on packet completion
- err  output  1  one-cycle pulse on error

Behaviour:
- Interface: single clock clk; reset rst is asynchronous and active-high.
- Reset values: pwm_config_data=CONFIG_RESET; all other outputs 0; state=IDLE; counters 0.
- Packet formats:
  - [CMD_CFG][NB bytes, LSB first]
  - [CMD_DATA][LEN][LEN data bytes]. LEN=0 is legal and means no data bytes.
- FSM states: IDLE, CFG, LEN, DATA.
  - IDLE + rx_valid, byte==CMD_CFG -> CFG, byte counter cleared.
  - IDLE + rx_valid, byte==CMD_DATA -> LEN.
  - IDLE + rx_valid, any other byte -> stay IDLE, err pulse next cycle.
  - CFG: each byte is shifted into a shadow register at bit position 8*count. On the NB-th byte:
    - pwm_config_data is loaded from shadow plus that byte, visible the cycle after that rx_valid.
    - config_update and pkt_done pulse in that same cycle.
    - Next state is IDLE.
  - LEN: LEN byte is latched into the remaining-byte counter.
    - LEN=0 -> pkt_done pulse next cycle, go to IDLE.
    - LEN>0 -> go to DATA.
  - DATA: each rx_valid byte causes the following:
    - If fifo_full=0: wr_fifo_enable=1 and wr_fifo_data=byte, for exactly one cycle, one cycle after rx_valid.
    - If fifo_full=1 (sampled in the rx_valid cycle): byte dropped, err pulse, byte still counted.
    - Remaining counter decrements. On the last byte, pkt_done pulses and next state is IDLE.
- pwm_config_data changes only on a complete CFG packet. Partial or aborted packets never alter it.
- Timeout:
  - Counter runs in every non-IDLE state and clears on each rx_valid.
  - On reaching TIMEOUT_CYCLES: err pulse, return to IDLE, shadow and counters discarded.
  - If rx_valid arrives in the expiry cycle, the byte wins: it is processed normally and the counter clears.
- Back-to-back rx_valid on consecutive cycles must be supported with no byte loss. Output strobes are registered with 1-cycle latency.
- wr_fifo_data holds its last value when wr_fifo_enable=0.
- Reset asserted mid-packet: immediate return to IDLE; pwm_config_data returns to CONFIG_RESET; no strobes are emitted.
- err and pkt_done may pulse in the same cycle, e.g. a last data byte dropped on full.

Test Plan:
- Reset, then 01 78 56 34 12 -> pwm_config_data=32'h12345678 one cycle after the last byte; config_update=1 and pkt_done=1 for one cycle; busy low afterwards.
- 02 03 AA BB CC with fifo_full=0 -> three wr_fifo_enable pulses carrying AA, BB, CC, each one cycle after its rx_valid; pkt_done after CC.
- 02 02 11 22 with fifo_full=1 during 22 -> one write (11); err pulse for 22; pkt_done still pulses; state returns to IDLE.
- 01 EF BE, then idle for TIMEOUT_CYCLES -> err pulse, state IDLE, pwm_config_data unchanged. A following 01 04 03 02 01 gives 32'h01020304.
- Byte 7F in IDLE -> err pulse, no state change. 02 00 -> pkt_done with no FIFO writes.
- Assert rst after 01 AA BB -> all outputs 0, pwm_config_data=CONFIG_RESET. A new full packet after release decodes correctly.
